// File: rtl/axis_unpack_lanes.sv
// Purpose : splits one AXI-Stream beat of KERNEL_SIZE lane slices into KERNEL_SIZE per-lane FIFOs,
//           each with its own tkeep mask, tlast bit, fill level and almost-full flag.
// Latency : 1 cycle from an accepted beat to m_axis_tvalid (fall-through head, no bypass).
// Backpressure: s_axis_tready drops when any kept lane is full, during flush, or while in reset.
//
// Ports:
//   clk, rst             single rising-edge clock, asynchronous active-high reset
//   flush                synchronous clear of every lane (beats priority over push/pop)
//   s_axis_*             wide input beat; lane i = tdata[i*DATA_WIDTH +: DATA_WIDTH], written if tkeep[i]
//   m_axis_*             per-lane head word, tlast and valid; per-lane ready
//   lane_level           per-lane occupancy 0..DEPTH, packed (PTR_WIDTH+1) bits per lane
//   lane_almost_full     per-lane level >= ALMOST_FULL_LVL

// Single-lane circular FIFO with a registered occupancy count.
// Latency: a write is visible at head_data after the writing edge; reads are fall-through.
// Backpressure: writes while full and reads while empty are ignored; flush clears everything.
module axis_unpack_lanes_fifo #(
  parameter int WIDTH     = 9,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic [PTR_WIDTH:0]   level,
  output logic                 full,
  output logic                 empty
);

  localparam logic [PTR_WIDTH:0]   LVL_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]   LVL_MAX = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 wr_en;
  logic                 rd_en;

  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);

  // Flush voids both sides of any handshake in the same cycle.
  assign wr_en = push & ~full  & ~flush;
  assign rd_en = pop  & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage is deliberately not reset; the head is masked by empty at the top level.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

module axis_unpack_lanes #(
  parameter int KERNEL_SIZE     = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 4,
  parameter int PTR_WIDTH       = 2,
  parameter int ALMOST_FULL_LVL = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KERNEL_SIZE-1:0]             s_axis_tkeep,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [KERNEL_SIZE-1:0]             m_axis_tready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KERNEL_SIZE-1:0]             m_axis_tlast,
  output logic [KERNEL_SIZE-1:0]             m_axis_tvalid,
  output logic [KERNEL_SIZE*(PTR_WIDTH+1)-1:0] lane_level,
  output logic [KERNEL_SIZE-1:0]             lane_almost_full
);

  localparam int               ENTRY_W = DATA_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH+1)'(ALMOST_FULL_LVL);

  logic [KERNEL_SIZE-1:0] lane_full;
  logic [KERNEL_SIZE-1:0] lane_empty;
  logic [KERNEL_SIZE-1:0] lane_push;
  logic [KERNEL_SIZE-1:0] lane_pop;
  logic                   beat_fire;

  // Only kept lanes can stall a beat. Built from registered full flags and tkeep,
  // never from tvalid. Held low while rst is asserted so the upstream sees no
  // acceptance during an asynchronous reset.
  assign s_axis_tready = ~rst & ~flush & ~|(lane_full & s_axis_tkeep);
  assign beat_fire     = s_axis_tvalid & s_axis_tready;

  // A beat with tkeep == 0 still fires and is simply dropped.
  assign lane_push = {KERNEL_SIZE{beat_fire}} & s_axis_tkeep;
  assign lane_pop  = m_axis_tvalid & m_axis_tready;

  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_lane
    logic [ENTRY_W-1:0]   head;
    logic [PTR_WIDTH:0]   level;

    axis_unpack_lanes_fifo #(
      .WIDTH     (ENTRY_W),
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (lane_push[i]),
      .push_data ({s_axis_tlast, s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]}),
      .pop       (lane_pop[i]),
      .head_data (head),
      .level     (level),
      .full      (lane_full[i]),
      .empty     (lane_empty[i])
    );

    assign m_axis_tvalid[i] = ~lane_empty[i];

    // Empty lanes drive zeros instead of whatever stale word sits at rd_ptr.
    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = lane_empty[i] ? '0 : head[DATA_WIDTH-1:0];
    assign m_axis_tlast[i] = ~lane_empty[i] & head[DATA_WIDTH];

    assign lane_level[i*(PTR_WIDTH+1) +: (PTR_WIDTH+1)] = level;
    assign lane_almost_full[i] = (level >= AF_LVL);
  end

endmodule

// File: tb/tb_axis_unpack_lanes.sv
module tb_axis_unpack_lanes;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [23:0] s_axis_tdata;
  logic [2:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [2:0]  m_axis_tready;
  logic [23:0] m_axis_tdata;
  logic [2:0]  m_axis_tlast;
  logic [2:0]  m_axis_tvalid;
  logic [8:0]  lane_level;
  logic [2:0]  lane_almost_full;

  int checks;
  int failures;

  axis_unpack_lanes #(
    .KERNEL_SIZE     (3),
    .DATA_WIDTH      (8),
    .DEPTH           (4),
    .PTR_WIDTH       (2),
    .ALMOST_FULL_LVL (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .lane_level       (lane_level),
    .lane_almost_full (lane_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs driven at the falling edge, outputs expected
  // from the state before the next rising edge.
  typedef struct {
    logic        fl;
    logic        tv;
    logic [2:0]  tk;
    logic        tl;
    logic [23:0] td;
    logic [2:0]  mr;
    logic        srdy;
    logic [2:0]  mvld;
    logic [23:0] mdata;
    logic [2:0]  mlast;
    logic [8:0]  lvl;
    logic [2:0]  af;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic fl, input logic tv, input logic [2:0] tk, input logic tl,
    input logic [23:0] td, input logic [2:0] mr,
    input logic srdy, input logic [2:0] mvld, input logic [23:0] mdata,
    input logic [2:0] mlast, input logic [8:0] lvl, input logic [2:0] af);
    vec_t v;
    v.fl = fl; v.tv = tv; v.tk = tk; v.tl = tl; v.td = td; v.mr = mr;
    v.srdy = srdy; v.mvld = mvld; v.mdata = mdata; v.mlast = mlast;
    v.lvl = lvl; v.af = af;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic srdy, input logic [2:0] mvld,
                             input logic [23:0] mdata, input logic [2:0] mlast,
                             input logic [8:0] lvl, input logic [2:0] af);
    chk({tag, ".s_tready"}, {31'd0, s_axis_tready}, {31'd0, srdy});
    chk({tag, ".m_tvalid"}, {29'd0, m_axis_tvalid}, {29'd0, mvld});
    chk({tag, ".m_tdata"},  {8'd0, m_axis_tdata},   {8'd0, mdata});
    chk({tag, ".m_tlast"},  {29'd0, m_axis_tlast},  {29'd0, mlast});
    chk({tag, ".level"},    {23'd0, lane_level},    {23'd0, lvl});
    chk({tag, ".afull"},    {29'd0, lane_almost_full}, {29'd0, af});
  endtask

  task automatic drive_idle();
    flush = 1'b0; s_axis_tvalid = 1'b0; s_axis_tkeep = 3'b000;
    s_axis_tlast = 1'b0; s_axis_tdata = 24'h0; m_axis_tready = 3'b000;
  endtask

  initial begin
    logic [7:0] hd;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive_idle();

    // Single beat, then pop all three lanes.
    tbl.push_back(mk(1'b0,1'b1,3'b111,1'b1,24'h332211,3'b000, 1'b1,3'b000,24'h000000,3'b000,9'h000,3'b000));
    tbl.push_back(mk(1'b0,1'b0,3'b000,1'b0,24'h000000,3'b111, 1'b1,3'b111,24'h332211,3'b111,9'h049,3'b000));
    // Fill lane 0 (0x01..0x04, last beat tlast), then a blocked kept beat and an accepted 110 beat.
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000001,3'b000, 1'b1,3'b000,24'h000000,3'b000,9'h000,3'b000));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000002,3'b000, 1'b1,3'b001,24'h000001,3'b000,9'h001,3'b000));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000003,3'b000, 1'b1,3'b001,24'h000001,3'b000,9'h002,3'b000));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b1,24'h000004,3'b000, 1'b1,3'b001,24'h000001,3'b000,9'h003,3'b001));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000005,3'b000, 1'b0,3'b001,24'h000001,3'b000,9'h004,3'b001));
    tbl.push_back(mk(1'b0,1'b1,3'b110,1'b0,24'hBBAA00,3'b000, 1'b1,3'b001,24'h000001,3'b000,9'h004,3'b001));
    // Full lane 0 with pop and kept beat: no push; next cycle accepts; then wrap 0x05..0x08.
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000005,3'b001, 1'b0,3'b111,24'hBBAA01,3'b000,9'h04C,3'b001));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000005,3'b000, 1'b1,3'b111,24'hBBAA02,3'b000,9'h04B,3'b001));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000006,3'b001, 1'b0,3'b111,24'hBBAA02,3'b000,9'h04C,3'b001));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000006,3'b001, 1'b1,3'b111,24'hBBAA03,3'b000,9'h04B,3'b001));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000007,3'b001, 1'b1,3'b111,24'hBBAA04,3'b001,9'h04B,3'b001));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b1,24'h000008,3'b001, 1'b1,3'b111,24'hBBAA05,3'b000,9'h04B,3'b001));
    tbl.push_back(mk(1'b0,1'b0,3'b000,1'b0,24'h000000,3'b001, 1'b1,3'b111,24'hBBAA06,3'b000,9'h04B,3'b001));
    tbl.push_back(mk(1'b0,1'b0,3'b000,1'b0,24'h000000,3'b001, 1'b1,3'b111,24'hBBAA07,3'b000,9'h04A,3'b000));
    tbl.push_back(mk(1'b0,1'b0,3'b000,1'b0,24'h000000,3'b001, 1'b1,3'b111,24'hBBAA08,3'b001,9'h049,3'b000));
    // Bring lane 1 to level 2 while draining lane 2, then 10 cycles of push+pop on lane 1.
    tbl.push_back(mk(1'b0,1'b1,3'b010,1'b0,24'h00CC00,3'b100, 1'b1,3'b110,24'hBBAA00,3'b000,9'h048,3'b000));
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      hd = 8'hAA;
      else if (j == 1) hd = 8'hCC;
      else             hd = 8'h10 + 8'(j - 2);
      tbl.push_back(mk(1'b0,1'b1,3'b010,1'b0,{8'h00, 8'h10 + 8'(j), 8'h00},3'b010,
                       1'b1,3'b010,{8'h00, hd, 8'h00},3'b000,9'h010,3'b000));
    end
    // Levels 3/2/1, then flush with all consumers ready and a kept beat present.
    tbl.push_back(mk(1'b0,1'b1,3'b101,1'b0,24'h310021,3'b000, 1'b1,3'b010,24'h001800,3'b000,9'h010,3'b000));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000022,3'b000, 1'b1,3'b111,24'h311821,3'b000,9'h051,3'b000));
    tbl.push_back(mk(1'b0,1'b1,3'b001,1'b0,24'h000023,3'b000, 1'b1,3'b111,24'h311821,3'b000,9'h052,3'b000));
    tbl.push_back(mk(1'b1,1'b1,3'b111,1'b0,24'hEEEEEE,3'b111, 1'b0,3'b111,24'h311821,3'b000,9'h053,3'b001));
    tbl.push_back(mk(1'b0,1'b0,3'b000,1'b0,24'h000000,3'b111, 1'b1,3'b000,24'h000000,3'b000,9'h000,3'b000));

    // Reset state.
    #3;
    chk_outputs("reset", 1'b0, 3'b000, 24'h0, 3'b000, 9'h000, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      flush         = tbl[r].fl;
      s_axis_tvalid = tbl[r].tv;
      s_axis_tkeep  = tbl[r].tk;
      s_axis_tlast  = tbl[r].tl;
      s_axis_tdata  = tbl[r].td;
      m_axis_tready = tbl[r].mr;
      #2;
      chk_outputs($sformatf("row%0d", r), tbl[r].srdy, tbl[r].mvld, tbl[r].mdata,
                  tbl[r].mlast, tbl[r].lvl, tbl[r].af);
    end

    // Asynchronous reset between edges with data in flight.
    @(negedge clk);
    drive_idle();
    s_axis_tvalid = 1'b1; s_axis_tkeep = 3'b111; s_axis_tdata = 24'h665544;
    @(negedge clk);
    s_axis_tdata = 24'h998877;
    #2;
    chk_outputs("pre_rst", 1'b1, 3'b111, 24'h665544, 3'b000, 9'h049, 3'b000);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    chk_outputs("async_rst", 1'b0, 3'b000, 24'h0, 3'b000, 9'h000, 3'b000);
    #1;
    rst = 1'b0;
    @(negedge clk);
    s_axis_tvalid = 1'b1; s_axis_tkeep = 3'b111; s_axis_tdata = 24'hCCBBAA; s_axis_tlast = 1'b0;
    #2;
    chk_outputs("post_rst0", 1'b1, 3'b000, 24'h0, 3'b000, 9'h000, 3'b000);
    @(negedge clk);
    drive_idle();
    #2;
    chk_outputs("post_rst1", 1'b1, 3'b111, 24'hCCBBAA, 3'b000, 9'h049, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
